hazard_controller: RTL and testbench

Pipeline hazard sequencer for the 5-stage MIPS core. It sits beside the forwarding logic in the decode/execute region. It detects load-use hazards, sequences multi-cycle mul/div occupancy of EX, and squashes wrong-path instructions on taken branches resolved in MEM. It drives the write-enable and flush controls of PC, IF/ID, ID/EX and EX/MEM.

---
 rtl/hazard_controller_if.sv | 29 ++
 rtl/hazard_controller.sv | 163 ++++++++++++++++
 tb/tb_hazard_controller.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_controller_if.sv
// Pipeline-side hazard signals between the MIPS datapath and hazard_controller.
// slave = the hazard controller, master = the datapath that feeds and obeys it.
interface hazard_controller_if;
    logic [4:0] IFID_Rs;
    logic [4:0] IFID_Rt;
    logic       IFID_usesRt;
    logic       IDEX_MemRead;
    logic [4:0] IDEX_Rt;
    logic       md_start;
    logic       branch_taken;
    logic       PCWrite;
    logic       IFIDWrite;
    logic       IDEXWrite;
    logic       IFID_flush;
    logic       IDEX_flush;
    logic       EXMEM_flush;
    logic       busy;
    logic       md_done;

    modport slave (
        input  IFID_Rs, IFID_Rt, IFID_usesRt, IDEX_MemRead, IDEX_Rt, md_start, branch_taken,
        output PCWrite, IFIDWrite, IDEXWrite, IFID_flush, IDEX_flush, EXMEM_flush, busy, md_done
    );

    modport master (
        output IFID_Rs, IFID_Rt, IFID_usesRt, IDEX_MemRead, IDEX_Rt, md_start, branch_taken,
        input  PCWrite, IFIDWrite, IDEXWrite, IFID_flush, IDEX_flush, EXMEM_flush, busy, md_done
    );
endinterface

// File: rtl/hazard_controller.sv
// Load-use stall, mul/div EX occupancy and MEM-resolved branch squash sequencer.
// Optional HAZARD_STATS_EN adds saturating stall_count / flush_count outputs.
module hazard_controller #(
    parameter int LU_STALL_CYCLES = 1,
    parameter int MD_LATENCY      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_controller_if.slave   hz
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]          stall_count,
    output logic [15:0]          flush_count
`endif
);

    typedef enum logic [1:0] {RUN, LU_STALL, MD_BUSY} state_t;

    state_t     state, state_nxt;
    logic [7:0] ctr, ctr_nxt;
    logic       lu;
    logic       br_apply;

    logic pc_we, ifid_we, idex_we, ifid_fl, idex_fl, exmem_fl, busy_o, md_done_o;

    assign lu = hz.IDEX_MemRead && (hz.IDEX_Rt != 5'd0) &&
                ((hz.IDEX_Rt == hz.IFID_Rs) || (hz.IFID_usesRt && (hz.IDEX_Rt == hz.IFID_Rt)));

    // A taken branch is only honoured in RUN or LU_STALL; MD_BUSY keeps EX/MEM bubbled.
    assign br_apply = !rst && hz.branch_taken && ((state == RUN) || (state == LU_STALL));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            ctr   <= 8'd0;
        end else begin
            state <= state_nxt;
            ctr   <= ctr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ctr_nxt   = ctr;
        case (state)
            RUN: begin
                if (hz.branch_taken) begin
                    state_nxt = RUN;
                end else if (hz.md_start) begin
                    ctr_nxt   = 8'(MD_LATENCY - 1);
                    state_nxt = MD_BUSY;
                end else if (lu && (LU_STALL_CYCLES > 1)) begin
                    ctr_nxt   = 8'(LU_STALL_CYCLES - 1);
                    state_nxt = LU_STALL;
                end
            end
            LU_STALL: begin
                if (hz.branch_taken) begin
                    ctr_nxt   = 8'd0;
                    state_nxt = RUN;
                end else begin
                    ctr_nxt = ctr - 8'd1;
                    if (ctr <= 8'd1) state_nxt = RUN;
                end
            end
            MD_BUSY: begin
                ctr_nxt = ctr - 8'd1;
                if (ctr <= 8'd1) begin
                    ctr_nxt   = 8'd0;
                    state_nxt = RUN;
                end
            end
            default: begin
                ctr_nxt   = 8'd0;
                state_nxt = RUN;
            end
        endcase
    end

    // Reset forces every control low regardless of state or inputs.
    always_comb begin
        pc_we     = 1'b1;
        ifid_we   = 1'b1;
        idex_we   = 1'b1;
        ifid_fl   = 1'b0;
        idex_fl   = 1'b0;
        exmem_fl  = 1'b0;
        md_done_o = 1'b0;
        busy_o    = (state != RUN);
        if (rst) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            idex_we = 1'b0;
            busy_o  = 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (hz.branch_taken) begin
                        ifid_fl  = 1'b1;
                        idex_fl  = 1'b1;
                        exmem_fl = 1'b1;
                    end else if (hz.md_start) begin
                        pc_we    = 1'b0;
                        ifid_we  = 1'b0;
                        idex_we  = 1'b0;
                        exmem_fl = 1'b1;
                    end else if (lu) begin
                        pc_we   = 1'b0;
                        ifid_we = 1'b0;
                        idex_fl = 1'b1;
                    end
                end
                LU_STALL: begin
                    if (hz.branch_taken) begin
                        ifid_fl  = 1'b1;
                        idex_fl  = 1'b1;
                        exmem_fl = 1'b1;
                    end else begin
                        pc_we   = 1'b0;
                        ifid_we = 1'b0;
                        idex_fl = 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (ctr > 8'd1) begin
                        pc_we    = 1'b0;
                        ifid_we  = 1'b0;
                        idex_we  = 1'b0;
                        exmem_fl = 1'b1;
                    end else begin
                        md_done_o = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hz.PCWrite     = pc_we;
    assign hz.IFIDWrite   = ifid_we;
    assign hz.IDEXWrite   = idex_we;
    assign hz.IFID_flush  = ifid_fl;
    assign hz.IDEX_flush  = idex_fl;
    assign hz.EXMEM_flush = exmem_fl;
    assign hz.busy        = busy_o;
    assign hz.md_done     = md_done_o;

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= 16'd0;
            flush_count <= 16'd0;
        end else begin
            if (!pc_we && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
            if (br_apply && (flush_count != 16'hFFFF)) flush_count <= flush_count + 16'd1;
        end
    end
`else
    logic unused_br;
    assign unused_br = br_apply;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: dut1 uses defaults, dut3 uses LU_STALL_CYCLES=3.
// Output vector order: {PCWrite,IFIDWrite,IDEXWrite,IFID_flush,IDEX_flush,EXMEM_flush,busy,md_done}.
module tb_hazard_controller;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesrt;
        logic       memread;
        logic [4:0] exrt;
        logic       md;
        logic       bt;
        logic [7:0] exp;
    } stim_t;

    localparam logic [7:0] DEF     = 8'b111_000_00;
    localparam logic [7:0] ZERO    = 8'b000_000_00;
    localparam logic [7:0] LU0     = 8'b001_010_00;
    localparam logic [7:0] LU1     = 8'b001_010_10;
    localparam logic [7:0] BR0     = 8'b111_111_00;
    localparam logic [7:0] BR1     = 8'b111_111_10;
    localparam logic [7:0] MD0     = 8'b000_001_00;
    localparam logic [7:0] MD1     = 8'b000_001_10;
    localparam logic [7:0] MDDONE  = 8'b111_000_11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [7:0] exp_q[$];

    hazard_controller_if if1();
    hazard_controller_if if3();

`ifdef HAZARD_STATS_EN
    logic [15:0] sc1, fc1, sc3, fc3;
`endif

    hazard_controller #(.LU_STALL_CYCLES(1), .MD_LATENCY(4)) dut1 (
        .clk(clk), .rst(rst), .hz(if1.slave)
`ifdef HAZARD_STATS_EN
        , .stall_count(sc1), .flush_count(fc1)
`endif
    );

    hazard_controller #(.LU_STALL_CYCLES(3), .MD_LATENCY(4)) dut3 (
        .clk(clk), .rst(rst), .hz(if3.slave)
`ifdef HAZARD_STATS_EN
        , .stall_count(sc3), .flush_count(fc3)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] obs1();
        return {if1.PCWrite, if1.IFIDWrite, if1.IDEXWrite, if1.IFID_flush,
                if1.IDEX_flush, if1.EXMEM_flush, if1.busy, if1.md_done};
    endfunction

    function automatic logic [7:0] obs3();
        return {if3.PCWrite, if3.IFIDWrite, if3.IDEXWrite, if3.IFID_flush,
                if3.IDEX_flush, if3.EXMEM_flush, if3.busy, if3.md_done};
    endfunction

    function automatic stim_t mk(logic [4:0] rs, logic [4:0] rt, logic usesrt, logic memread,
                                 logic [4:0] exrt, logic md, logic bt, logic [7:0] exp);
        stim_t s;
        s.rs = rs; s.rt = rt; s.usesrt = usesrt; s.memread = memread;
        s.exrt = exrt; s.md = md; s.bt = bt; s.exp = exp;
        return s;
    endfunction

    // Drives the same inputs to both DUTs mid-cycle, away from the rising edge.
    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        if1.IFID_Rs = s.rs;   if3.IFID_Rs = s.rs;
        if1.IFID_Rt = s.rt;   if3.IFID_Rt = s.rt;
        if1.IFID_usesRt = s.usesrt;   if3.IFID_usesRt = s.usesrt;
        if1.IDEX_MemRead = s.memread; if3.IDEX_MemRead = s.memread;
        if1.IDEX_Rt = s.exrt; if3.IDEX_Rt = s.exrt;
        if1.md_start = s.md;  if3.md_start = s.md;
        if1.branch_taken = s.bt;      if3.branch_taken = s.bt;
    endtask

    task automatic doReset();
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, DEF));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] o;
        applyStimulus(mk(5'd8, 5'd8, 1, 1, 5'd8, 1, 1, ZERO));
        rst = 1'b1;
        #1;
        o = obs1(); total++;
        if (o !== ZERO) begin bad++; $display("[TB] FAIL reset_dut1: got %b expected %b", o, ZERO); end
        o = obs3(); total++;
        if (o !== ZERO) begin bad++; $display("[TB] FAIL reset_dut3: got %b expected %b", o, ZERO); end
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, DEF));
        rst = 1'b0;
        #1;
        o = obs1(); total++;
        if (o !== DEF) begin bad++; $display("[TB] FAIL reset_release: got %b expected %b", o, DEF); end
    endtask

    task automatic test_load_use_default();
        stim_t s[$];
        logic [7:0] o, e;
        s.push_back(mk(5'd8, 5'd0, 0, 1, 5'd8, 0, 0, LU0));
        s.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, DEF));
        s.push_back(mk(5'd0, 5'd0, 1, 1, 5'd0, 0, 0, DEF));
        s.push_back(mk(5'd3, 5'd8, 0, 1, 5'd8, 0, 0, DEF));
        s.push_back(mk(5'd3, 5'd8, 1, 1, 5'd8, 0, 0, LU0));
        s.push_back(mk(5'd8, 5'd8, 1, 0, 5'd8, 0, 0, DEF));
        s.push_back(mk(5'd9, 5'd8, 1, 1, 5'd7, 0, 0, DEF));
        doReset();
        foreach (s[i]) begin
            applyStimulus(s[i]);
            exp_q.push_back(s[i].exp);
            #1;
            o = obs1();
            e = exp_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("[TB] FAIL load_use_default[%0d]: got %b expected %b", i, o, e); end
        end
    endtask

    task automatic test_load_use_stall3();
        stim_t s[$];
        logic [7:0] o, e;
        s.push_back(mk(5'd8, 5'd0, 0, 1, 5'd8, 0, 0, LU0));
        s.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, LU1));
        s.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, LU1));
        s.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, DEF));
        s.push_back(mk(5'd4, 5'd4, 1, 1, 5'd4, 0, 0, LU0));
        s.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, BR1));
        s.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, DEF));
        doReset();
        foreach (s[i]) begin
            applyStimulus(s[i]);
            exp_q.push_back(s[i].exp);
            #1;
            o = obs3();
            e = exp_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("[TB] FAIL load_use_stall3[%0d]: got %b expected %b", i, o, e); end
        end
    endtask

    task automatic test_muldiv();
        stim_t s[$];
        logic [7:0] o, e;
        s.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 1, 0, MD0));
        s.push_back(mk(5'd8, 5'd0, 0, 1, 5'd8, 0, 1, MD1));
        s.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, MD1));
        s.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, MDDONE));
        s.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, DEF));
        s.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, DEF));
        doReset();
        foreach (s[i]) begin
            applyStimulus(s[i]);
            exp_q.push_back(s[i].exp);
            #1;
            o = obs1();
            e = exp_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("[TB] FAIL muldiv[%0d]: got %b expected %b", i, o, e); end
        end
    endtask

    task automatic test_simultaneous();
        stim_t s[$];
        logic [7:0] o, e;
        s.push_back(mk(5'd8, 5'd0, 0, 1, 5'd8, 1, 1, BR0));
        s.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, DEF));
        s.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, DEF));
        s.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, DEF));
        s.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, DEF));
        doReset();
        foreach (s[i]) begin
            applyStimulus(s[i]);
            exp_q.push_back(s[i].exp);
            #1;
            o = obs1();
            e = exp_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("[TB] FAIL simultaneous[%0d]: got %b expected %b", i, o, e); end
        end
    endtask

    task automatic test_reset_mid_muldiv();
        logic [7:0] o, e;
        doReset();
        applyStimulus(mk(5'd0, 5'd0, 0, 0, 5'd0, 1, 0, MD0));
        exp_q.push_back(MD0);
        #1;
        o = obs1(); e = exp_q.pop_front(); total++;
        if (o !== e) begin bad++; $display("[TB] FAIL rst_md_c1: got %b expected %b", o, e); end
        applyStimulus(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, MD1));
        exp_q.push_back(MD1);
        #1;
        o = obs1(); e = exp_q.pop_front(); total++;
        if (o !== e) begin bad++; $display("[TB] FAIL rst_md_c2: got %b expected %b", o, e); end
        #1 rst = 1'b1;
        exp_q.push_back(ZERO);
        #1;
        o = obs1(); e = exp_q.pop_front(); total++;
        if (o !== e) begin bad++; $display("[TB] FAIL rst_md_async: got %b expected %b", o, e); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, DEF));
            exp_q.push_back(DEF);
            #1;
            o = obs1(); e = exp_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("[TB] FAIL rst_md_after[%0d]: got %b expected %b", i, o, e); end
        end
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        doReset();
        #1;
        total++;
        if (fc1 !== 16'd0 || sc1 !== 16'd0) begin
            bad++; $display("[TB] FAIL stats_reset: got %h/%h expected 0000/0000", sc1, fc1);
        end
        applyStimulus(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, BR0));
        applyStimulus(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, DEF));
        applyStimulus(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, BR0));
        applyStimulus(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, DEF));
        #1;
        total++;
        if (fc1 !== 16'd2) begin bad++; $display("[TB] FAIL flush_count: got %0d expected 2", fc1); end
        for (int i = 0; i < 70000; i++) applyStimulus(mk(5'd8, 5'd0, 0, 1, 5'd8, 0, 0, LU0));
        applyStimulus(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, DEF));
        #1;
        total++;
        if (sc1 !== 16'hFFFF) begin bad++; $display("[TB] FAIL stall_count_sat: got %h expected ffff", sc1); end
    endtask
`endif

    initial begin
        test_reset();
        test_load_use_default();
        test_load_use_stall3();
        test_muldiv();
        test_simultaneous();
        test_reset_mid_muldiv();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
